sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter and access sequencer for the single shared data SRAM of the pipelined CPU. It lets the CPU load/store path and an auxiliary port (program loader / debug monitor) take turns on the SRAM. Each access runs through a fixed SETUP → ACCESS → DONE sequence that drives the SRAM address, chip select and read/write strobes. The block sits between the Writeback-stage memory control and the SRAM, replacing the direct wiring from the writeback control bits to the SRAM strobes.

## Interface
Parameters:
- WAIT_CYCLES, 1: number of ACCESS-state cycles per transfer; legal range 1–4.

Ports:
- CLK  in  1  single system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-low; sampled on CLK rising edge.
- CpuReq  in  1  CPU access request; level, held until CpuDone.
- CpuWr  in  1  1 = write, 0 = read; valid while CpuReq is high.
- CpuAdx  in  11  CPU word address.
- CpuWData  in  32  CPU write data.
- CpuGnt  out  1  one-cycle pulse: CPU request accepted.
- CpuDone  out  1  one-cycle pulse: CPU transfer complete; CpuRData valid.
- CpuRData  out  32  read data; held until the next CPU read completes.
- AuxReq, AuxWr, AuxAdx[11], AuxWData[32]  in  same meaning as the CPU port, for the auxiliary requester.
- AuxGnt, AuxDone, AuxRData[32]  out  same meaning as the CPU port, for the auxiliary requester.
- SramAdx  out  11  SRAM address.
- SramDout  out  32  SRAM write data; driven only when SramWE is high, 0 otherwise.
- SramDin  in  32  SRAM read data.
- SramCS  out  1  chip select.
- SramWE  out  1  write enable.
- SramOE  out  1  output enable.
- Busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered or decoded from registered state only.
- IDLE:
  - If any Req is high, choose a winner and latch its Wr, Adx and WData into internal registers. The owner register records the winner.
  - Next state is SETUP. With no Req, stay in IDLE.
- Arbitration (round-robin on a LastGnt bit):
  - Only one requester: it wins.
  - Both requesting: the requester not recorded in LastGnt wins.
  - LastGnt updates when the FSM enters SETUP.
- SETUP (1 cycle):
  - The owner's Gnt is high for this cycle only.
  - SramCS = 1 and SramAdx = latched address.
  - Write: SramWE = 1, SramDout = latched data. Read: SramOE = 1.
- ACCESS (WAIT_CYCLES cycles, counted by an internal counter):
  - Strobes and address are held unchanged.
  - Read: on the last ACCESS cycle, capture SramDin into the owner's RData register.
- DONE (1 cycle):
  - SramCS, SramWE and SramOE are low.
  - The owner's Done is high for this cycle only.
  - Next state is IDLE.
- Requester rule: a requester deasserts Req at the clock edge that ends its Done cycle. If Req is still high in the following IDLE cycle, it is a new request.
- Req changes after acceptance are ignored. Latched values are used and the transfer always completes.
- Only the owner's RData register is updated. The non-owner's RData holds its value.

## Timing
- Reset values (applied when Reset = 0 at a rising edge):
  - State = IDLE.
  - All Gnt, Done, SramCS, SramWE and SramOE = 0; Busy = 0.
  - SramAdx = 0, SramDout = 0, CpuRData = AuxRData = 0.
  - LastGnt = Aux, so the CPU wins the first tie.
  - Wait counter = 0.
- Reset mid-transfer aborts it immediately. No Done is issued, and strobes are low in the cycle after the reset edge.
- Request latency, with Req first seen high at edge k in IDLE:
  - Gnt is high in cycle k+1.
  - Done is high in cycle k+2+WAIT_CYCLES.
- Minimum transfer period: 3+WAIT_CYCLES cycles (4 when WAIT_CYCLES = 1).
- Sustained contention alternates owners, so each requester's worst-case wait is one other transfer.
- SramAdx, SramDout and the strobes are stable from the start of SETUP through the end of ACCESS.

## Test plan
- Single CPU read, WAIT_CYCLES = 1, CpuAdx = 0x005, SRAM model returns 0xDEADBEEF:
  - CpuGnt at k+1, SramOE high k+1..k+2, CpuDone at k+3, CpuRData = 0xDEADBEEF.
  - AuxRData stays 0.
- Aux write, AuxAdx = 0x7FF, AuxWData = 0x12345678:
  - SramWE high for 2 cycles, SramAdx = 0x7FF, SramDout = 0x12345678, AuxDone once.
  - Readback by the CPU returns 0x12345678.
- Both Req high from reset and held continuously:
  - Grant order is CPU, Aux, CPU, Aux, with a Done every 4 cycles.
  - No Gnt overlap.
- Reset asserted during ACCESS:
  - Next cycle: state IDLE, strobes 0, no Done pulse.
  - A subsequent CPU read completes normally.
- WAIT_CYCLES = 3:
  - SramCS high for 4 cycles and Done 5 cycles after Req is sampled.
  - CpuAdx changed after CpuGnt does not change SramAdx.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and SETUP/ACCESS/DONE access sequencer that shares the
// data SRAM between the CPU load/store path and an auxiliary requester.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWr,
    input  logic [10:0] CpuAdx,
    input  logic [31:0] CpuWData,
    output logic        CpuGnt,
    output logic        CpuDone,
    output logic [31:0] CpuRData,
    input  logic        AuxReq,
    input  logic        AuxWr,
    input  logic [10:0] AuxAdx,
    input  logic [31:0] AuxWData,
    output logic        AuxGnt,
    output logic        AuxDone,
    output logic [31:0] AuxRData,
    output logic [10:0] SramAdx,
    output logic [31:0] SramDout,
    input  logic [31:0] SramDin,
    output logic        SramCS,
    output logic        SramWE,
    output logic        SramOE,
    output logic        Busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;       // 1 = Aux owns the current transfer
    logic        last_gnt_q, last_gnt_d; // 1 = Aux was granted last
    logic        wr_q, wr_d;
    logic [10:0] adx_q, adx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] aux_rdata_q, aux_rdata_d;
    logic        cpu_gnt_q, cpu_gnt_d, aux_gnt_q, aux_gnt_d;
    logic        cpu_done_q, cpu_done_d, aux_done_q, aux_done_d;
    logic        cs_q, cs_d, we_q, we_d, oe_q, oe_d, busy_q, busy_d;
    logic [31:0] dout_q, dout_d;
    logic        win_aux_s;

    // On a tie the requester not granted last wins
    assign win_aux_s = AuxReq & (~CpuReq | ~last_gnt_q);

    // Next-state, request latching and read-data capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        wr_d        = wr_q;
        adx_d       = adx_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (CpuReq | AuxReq) begin
                    state_d    = S_SETUP;
                    owner_d    = win_aux_s;
                    last_gnt_d = win_aux_s;
                    wr_d       = win_aux_s ? AuxWr : CpuWr;
                    adx_d      = win_aux_s ? AuxAdx : CpuAdx;
                    wdata_d    = win_aux_s ? AuxWData : CpuWData;
                    cnt_d      = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = 2'd0;
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    cnt_d   = 2'd0;
                    if (!wr_q && owner_q) begin
                        aux_rdata_d = SramDin;
                    end else if (!wr_q) begin
                        cpu_rdata_d = SramDin;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        cs_d       = (state_d == S_SETUP) || (state_d == S_ACCESS);
        we_d       = cs_d & wr_d;
        oe_d       = cs_d & ~wr_d;
        dout_d     = we_d ? wdata_d : 32'd0;
        cpu_gnt_d  = (state_d == S_SETUP) & ~owner_d;
        aux_gnt_d  = (state_d == S_SETUP) & owner_d;
        cpu_done_d = (state_d == S_DONE) & ~owner_d;
        aux_done_d = (state_d == S_DONE) & owner_d;
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'b1;
            wr_q        <= 1'b0;
            adx_q       <= 11'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 2'd0;
            cpu_rdata_q <= 32'd0;
            aux_rdata_q <= 32'd0;
            cpu_gnt_q   <= 1'b0;
            aux_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            aux_done_q  <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            wr_q        <= wr_d;
            adx_q       <= adx_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
            cpu_gnt_q   <= cpu_gnt_d;
            aux_gnt_q   <= aux_gnt_d;
            cpu_done_q  <= cpu_done_d;
            aux_done_q  <= aux_done_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
        end
    end

    assign CpuGnt   = cpu_gnt_q;
    assign AuxGnt   = aux_gnt_q;
    assign CpuDone  = cpu_done_q;
    assign AuxDone  = aux_done_q;
    assign CpuRData = cpu_rdata_q;
    assign AuxRData = aux_rdata_q;
    assign SramAdx  = adx_q;
    assign SramDout = dout_q;
    assign SramCS   = cs_q;
    assign SramWE   = we_q;
    assign SramOE   = oe_q;
    assign Busy     = busy_q;

endmodule
